target_scheduler: RTL and testbench



---
 rtl/target_scheduler.sv | 182 ++++++++++++++++++
 tb/tb_target_scheduler.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/target_scheduler.sv
// Target scheduler: picks a detected 3x3 grid cell round-robin, hands it to the
// servo, waits for the aim, confirms the target over several frames, then fires.
module target_scheduler #(
    parameter int unsigned DWELL_FRAMES = 30,
    parameter int unsigned FIRE_CYCLES  = 100,
    parameter int unsigned AIM_TIMEOUT  = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       frame_end,
    input  logic [8:0] zone_hit,
    output logic       cmd_valid,
    output logic [3:0] cmd_zone,
    input  logic       cmd_ready,
    input  logic       aim_done,
    output logic       fire,
    output logic [3:0] active_zone,
    output logic       busy,
    output logic       timeout
);

    localparam int unsigned ZONES      = 9;
    localparam int unsigned ZONE_W     = 4;
    localparam int unsigned DWELL_W    = 8;
    localparam int unsigned TIMER_W    = 16;
    localparam logic [ZONE_W-1:0]  NO_ZONE    = 4'hF;
    localparam logic [ZONE_W-1:0]  FIRST_LAST = ZONE_W'(ZONES - 1);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_FRAMES - 1);
    localparam logic [TIMER_W-1:0] AIM_LAST   = TIMER_W'(AIM_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] FIRE_LAST  = TIMER_W'(FIRE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_ISSUE,
        S_AIM,
        S_DWELL,
        S_FIRE
    } state_t;

    state_t              state;
    logic [ZONES-1:0]    hit_mask;
    logic [ZONE_W-1:0]   last_zone;
    logic [TIMER_W-1:0]  aim_timer;
    logic [DWELL_W-1:0]  frame_cnt;
    logic [TIMER_W-1:0]  fire_cnt;

    logic [ZONE_W:0]     rr_sum;
    logic [ZONE_W-1:0]   rr_cand;
    logic [ZONE_W-1:0]   rr_zone;
    logic                rr_found;

    // Round-robin search: first set cell of hit_mask starting just after last_zone
    always_comb begin
        rr_sum   = '0;
        rr_cand  = '0;
        rr_zone  = '0;
        rr_found = 1'b0;
        for (int i = 1; i <= int'(ZONES); i++) begin
            rr_sum = (ZONE_W+1)'(last_zone) + (ZONE_W+1)'(i);
            if (rr_sum >= (ZONE_W+1)'(ZONES)) begin
                rr_sum = rr_sum - (ZONE_W+1)'(ZONES);
            end
            rr_cand = rr_sum[ZONE_W-1:0];
            if (!rr_found && hit_mask[rr_cand]) begin
                rr_zone  = rr_cand;
                rr_found = 1'b1;
            end
        end
    end

    // Scheduler FSM with registered outputs; every exit to IDLE clears busy and the overlay
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            cmd_valid   <= 1'b0;
            cmd_zone    <= '0;
            fire        <= 1'b0;
            timeout     <= 1'b0;
            busy        <= 1'b0;
            active_zone <= NO_ZONE;
            last_zone   <= FIRST_LAST;
            hit_mask    <= '0;
            aim_timer   <= '0;
            frame_cnt   <= '0;
            fire_cnt    <= '0;
        end else begin
            timeout <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (frame_end && enable && (zone_hit != '0)) begin
                        hit_mask <= zone_hit;
                        busy     <= 1'b1;
                        state    <= S_SELECT;
                    end
                end
                S_SELECT: begin
                    if (!enable || !rr_found) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        cmd_zone    <= rr_zone;
                        active_zone <= rr_zone;
                        cmd_valid   <= 1'b1;
                        state       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // Handshake always completes; enable only decides where we go next
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        aim_timer <= '0;
                        if (enable) begin
                            state <= S_AIM;
                        end else begin
                            busy        <= 1'b0;
                            active_zone <= NO_ZONE;
                            state       <= S_IDLE;
                        end
                    end
                end
                S_AIM: begin
                    if (!enable) begin
                        busy        <= 1'b0;
                        active_zone <= NO_ZONE;
                        state       <= S_IDLE;
                    end else if (aim_done) begin
                        frame_cnt <= '0;
                        state     <= S_DWELL;
                    end else if (aim_timer == AIM_LAST) begin
                        timeout     <= 1'b1;
                        busy        <= 1'b0;
                        active_zone <= NO_ZONE;
                        state       <= S_IDLE;
                    end else begin
                        aim_timer <= aim_timer + TIMER_W'(1);
                    end
                end
                S_DWELL: begin
                    if (!enable) begin
                        busy        <= 1'b0;
                        active_zone <= NO_ZONE;
                        state       <= S_IDLE;
                    end else if (frame_end) begin
                        if (!zone_hit[cmd_zone]) begin
                            busy        <= 1'b0;
                            active_zone <= NO_ZONE;
                            state       <= S_IDLE;
                        end else if (frame_cnt == DWELL_LAST) begin
                            fire     <= 1'b1;
                            fire_cnt <= '0;
                            state    <= S_FIRE;
                        end else begin
                            frame_cnt <= frame_cnt + DWELL_W'(1);
                        end
                    end
                end
                S_FIRE: begin
                    // Pulse runs to completion regardless of enable
                    if (fire_cnt == FIRE_LAST) begin
                        fire        <= 1'b0;
                        last_zone   <= cmd_zone;
                        busy        <= 1'b0;
                        active_zone <= NO_ZONE;
                        state       <= S_IDLE;
                    end else begin
                        fire_cnt <= fire_cnt + TIMER_W'(1);
                    end
                end
                default: begin
                    cmd_valid   <= 1'b0;
                    fire        <= 1'b0;
                    busy        <= 1'b0;
                    active_zone <= NO_ZONE;
                    state       <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_target_scheduler.sv
// Bench for target_scheduler: directed scenarios, a behavioural model checked every cycle,
// and literal expectations for the key scenario results.
module tb_target_scheduler;

    localparam int unsigned DWELL = 30;
    localparam int unsigned FIREC = 100;
    localparam int unsigned AIMTO = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       frame_end;
    logic [8:0] zone_hit;
    logic       cmd_valid;
    logic [3:0] cmd_zone;
    logic       cmd_ready;
    logic       aim_done;
    logic       fire;
    logic [3:0] active_zone;
    logic       busy;
    logic       timeout;

    int n_cmp  = 0;
    int n_fail = 0;
    int hs_cnt = 0;
    int fire_seen = 0;

    always #5 clk = ~clk;

    target_scheduler #(
        .DWELL_FRAMES(DWELL),
        .FIRE_CYCLES (FIREC),
        .AIM_TIMEOUT (AIMTO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .frame_end  (frame_end),
        .zone_hit   (zone_hit),
        .cmd_valid  (cmd_valid),
        .cmd_zone   (cmd_zone),
        .cmd_ready  (cmd_ready),
        .aim_done   (aim_done),
        .fire       (fire),
        .active_zone(active_zone),
        .busy       (busy),
        .timeout    (timeout)
    );

    task automatic check(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Behavioural model: phase 0 idle, 1 select, 2 issue, 3 aim, 4 dwell, 5 fire
    int         m_phase, m_zone, m_last, m_aim_left, m_frames_left, m_fire_left;
    logic [8:0] m_mask;
    bit         m_to, m_found;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_phase = 0;
            m_zone  = 0;
            m_last  = 8;
            m_mask  = '0;
            m_to    = 1'b0;
        end else begin
            m_to = 1'b0;
            case (m_phase)
                0: if (frame_end && enable && zone_hit != 9'd0) begin
                    m_mask  = zone_hit;
                    m_phase = 1;
                end
                1: if (!enable) m_phase = 0;
                   else begin
                       m_found = 1'b0;
                       for (int d = 1; d <= 9; d++) begin
                           if (!m_found && m_mask[(m_last + d) % 9]) begin
                               m_zone  = (m_last + d) % 9;
                               m_found = 1'b1;
                           end
                       end
                       m_phase = 2;
                   end
                2: if (cmd_ready) begin
                    m_phase    = enable ? 3 : 0;
                    m_aim_left = AIMTO;
                end
                3: if (!enable) m_phase = 0;
                   else if (aim_done) begin
                       m_phase       = 4;
                       m_frames_left = DWELL;
                   end else begin
                       m_aim_left--;
                       if (m_aim_left == 0) begin
                           m_to    = 1'b1;
                           m_phase = 0;
                       end
                   end
                4: if (!enable) m_phase = 0;
                   else if (frame_end) begin
                       if (zone_hit[m_zone]) begin
                           m_frames_left--;
                           if (m_frames_left == 0) begin
                               m_phase     = 5;
                               m_fire_left = FIREC;
                           end
                       end else m_phase = 0;
                   end
                5: begin
                    m_fire_left--;
                    if (m_fire_left == 0) begin
                        m_last  = m_zone;
                        m_phase = 0;
                    end
                end
                default: m_phase = 0;
            endcase
        end
    end

    // Handshake counter (values just before the edge)
    always @(posedge clk) begin
        if (!reset && cmd_valid && cmd_ready) hs_cnt++;
    end

    // Per-cycle comparison against the model
    always @(posedge clk) begin
        #1;
        if (fire) fire_seen++;
        check("cmd_valid", int'(cmd_valid), int'(m_phase == 2));
        check("cmd_zone", int'(cmd_zone), m_zone);
        check("active_zone", int'(active_zone), (m_phase >= 2) ? m_zone : 15);
        check("fire", int'(fire), int'(m_phase == 5));
        check("busy", int'(busy), int'(m_phase != 0));
        check("timeout", int'(timeout), int'(m_to));
    end

    // Target detected at frame_end; with cmd_ready high, returns on the negedge after AIM entry
    task automatic launch(input logic [8:0] hits);
        frame_end = 1'b1;
        zone_hit  = hits;
        @(negedge clk);
        frame_end = 1'b0;
        zone_hit  = '0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic frames(input int n, input logic [8:0] hits);
        for (int f = 0; f < n; f++) begin
            frame_end = 1'b1;
            zone_hit  = hits;
            @(negedge clk);
            frame_end = 1'b0;
            zone_hit  = '0;
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic aim_pulse(input int delay);
        repeat (delay) @(negedge clk);
        aim_done = 1'b1;
        @(negedge clk);
        aim_done = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int max_cycles);
        int k = 0;
        while (busy && k < max_cycles) begin
            @(negedge clk);
            k++;
        end
        check(name, int'(busy), 0);
    endtask

    initial begin
        int k;
        reset = 1'b1; enable = 1'b0; frame_end = 1'b0; zone_hit = '0;
        cmd_ready = 1'b1; aim_done = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cmd_valid", int'(cmd_valid), 0);
        check("rst_cmd_zone", int'(cmd_zone), 0);
        check("rst_active", int'(active_zone), 15);
        check("rst_busy", int'(busy), 0);
        check("rst_fire", int'(fire), 0);
        check("rst_timeout", int'(timeout), 0);
        reset = 1'b0; enable = 1'b1;
        @(negedge clk);

        // Happy path on cell 4; a frame_end with no hit coincides with aim_done and is ignored
        hs_cnt = 0; fire_seen = 0;
        launch(9'h010);
        check("hp_cmd_zone", int'(cmd_zone), 4);
        check("hp_active", int'(active_zone), 4);
        check("hp_handshakes", hs_cnt, 1);
        repeat (9) @(negedge clk);
        aim_done = 1'b1; frame_end = 1'b1; zone_hit = 9'h000;
        @(negedge clk);
        aim_done = 1'b0; frame_end = 1'b0;
        check("hp_coincident_frame_ignored", int'(busy), 1);
        frames(30, 9'h010);
        wait_idle("hp_wait_idle", 300);
        check("hp_fire_cycles", fire_seen, 100);
        check("hp_active_after", int'(active_zone), 15);

        // Round-robin skips cell 4, plus backpressure on the command
        cmd_ready = 1'b0; fire_seen = 0;
        frame_end = 1'b1; zone_hit = 9'h014;
        @(negedge clk);
        frame_end = 1'b0; zone_hit = '0;
        @(negedge clk);
        check("rr_first", int'(cmd_zone), 2);
        check("bp_valid_start", int'(cmd_valid), 1);
        hs_cnt = 0;
        repeat (20) @(negedge clk);
        check("bp_valid_held", int'(cmd_valid), 1);
        check("bp_zone_held", int'(cmd_zone), 2);
        check("bp_no_handshake", hs_cnt, 0);
        cmd_ready = 1'b1;
        @(negedge clk);
        check("bp_valid_drop", int'(cmd_valid), 0);
        check("bp_one_handshake", hs_cnt, 1);
        aim_pulse(3);
        frames(30, 9'h004);
        wait_idle("rr_wait_idle", 300);
        check("rr_fire_cycles", fire_seen, 100);

        // Next search starts after cell 2, so cell 4 wins; then let the aim time out
        launch(9'h014);
        check("rr_second", int'(cmd_zone), 4);
        k = 0;
        while (!timeout && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("to_latency", k, 16);
        @(negedge clk);
        check("to_width", int'(timeout), 0);
        check("to_idle", int'(busy), 0);
        check("to_active", int'(active_zone), 15);

        // last_zone still 2 after the timeout, so cell 4 again; target lost on frame 5
        launch(9'h014);
        check("to_last_kept", int'(cmd_zone), 4);
        aim_pulse(2);
        fire_seen = 0;
        frames(4, 9'h010);
        check("lost_still_busy", int'(busy), 1);
        frames(1, 9'h004);
        check("lost_idle", int'(busy), 0);
        check("lost_active", int'(active_zone), 15);
        check("lost_no_fire", fire_seen, 0);

        // Enable dropped in DWELL
        launch(9'h014);
        aim_pulse(2);
        frames(2, 9'h010);
        enable = 1'b0;
        @(negedge clk);
        check("en_abort_busy", int'(busy), 0);
        check("en_abort_active", int'(active_zone), 15);
        enable = 1'b1;
        @(negedge clk);

        // Asynchronous reset in the middle of the fire pulse
        launch(9'h010);
        aim_pulse(2);
        frames(30, 9'h010);
        repeat (5) @(negedge clk);
        check("pre_rst_fire", int'(fire), 1);
        reset = 1'b1;
        #1;
        check("arst_fire", int'(fire), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_cmd_valid", int'(cmd_valid), 0);
        check("arst_cmd_zone", int'(cmd_zone), 0);
        check("arst_active", int'(active_zone), 15);
        check("arst_timeout", int'(timeout), 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset restores the search origin: cell 0 first, so 9'h014 picks cell 2
        launch(9'h014);
        check("rst_last_zone", int'(cmd_zone), 2);
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end

endmodule
